// File: rtl/odd_even_sorter.sv
// Serial-in/serial-out sorter: loads N words, runs N odd-even transposition
// phases in place, then streams the sorted frame out.
module odd_even_sorter #(
    parameter int DATA_W = 32,
    parameter int N      = 10,
    parameter bit SIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_serial_i,
    input  logic              valid_i,
    input  logic              desc_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] data_serial_o,
    output logic              valid_o,
    output logic              busy_o
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [CW-1:0] NCNT = CW'(N);

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_SORT = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     ld_cnt_q, ld_cnt_d;
    logic [CW-1:0]     ph_q, ph_d;
    logic [CW-1:0]     k_q, k_d;
    logic              desc_q, desc_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              vout_q, vout_d;
    logic [DATA_W-1:0] mem_q [N];
    logic [DATA_W-1:0] mem_d [N];

    function automatic logic out_of_order(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic              desc
    );
        logic gt;
        logic lt;
        if (SIGNED) begin
            gt = $signed(a) > $signed(b);
            lt = $signed(a) < $signed(b);
        end else begin
            gt = a > b;
            lt = a < b;
        end
        return desc ? lt : gt;
    endfunction

    always_comb begin
        state_d  = state_q;
        ld_cnt_d = ld_cnt_q;
        ph_d     = ph_q;
        k_d      = k_q;
        desc_d   = desc_q;
        dout_d   = dout_q;
        vout_d   = 1'b0;
        mem_d    = mem_q;
        unique case (state_q)
            S_LOAD: begin
                if (valid_i) begin
                    for (int i = 0; i < N; i++) begin
                        if (ld_cnt_q == CW'(i)) begin
                            mem_d[i] = data_serial_i;
                        end
                    end
                    if (ld_cnt_q == '0) begin
                        desc_d = desc_i;
                    end
                    if (ld_cnt_q == LAST) begin
                        state_d  = S_SORT;
                        ld_cnt_d = '0;
                        ph_d     = '0;
                    end else begin
                        ld_cnt_d = ld_cnt_q + 1'b1;
                    end
                end
            end
            S_SORT: begin
                // pairs within one phase are disjoint, so all swap in parallel
                for (int i = 0; i < N - 1; i++) begin
                    if (i[0] == ph_q[0] &&
                        out_of_order(mem_q[i], mem_q[i+1], desc_q)) begin
                        mem_d[i]   = mem_q[i+1];
                        mem_d[i+1] = mem_q[i];
                    end
                end
                if (ph_q == LAST) begin
                    state_d = S_OUT;
                    ph_d    = '0;
                    k_d     = '0;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            S_OUT: begin
                // k == N is a drain cycle so the last word stays visible
                if (k_q == NCNT) begin
                    state_d  = S_LOAD;
                    k_d      = '0;
                    ld_cnt_d = '0;
                end else begin
                    for (int i = 0; i < N; i++) begin
                        if (k_q == CW'(i)) begin
                            dout_d = mem_q[i];
                        end
                    end
                    vout_d = 1'b1;
                    k_d    = k_q + 1'b1;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_LOAD;
            ld_cnt_q <= '0;
            ph_q     <= '0;
            k_q      <= '0;
            desc_q   <= 1'b0;
            dout_q   <= '0;
            vout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ld_cnt_q <= ld_cnt_d;
            ph_q     <= ph_d;
            k_q      <= k_d;
            desc_q   <= desc_d;
            dout_q   <= dout_d;
            vout_q   <= vout_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign ready_o       = (state_q == S_LOAD);
    assign busy_o        = (state_q != S_LOAD);
    assign valid_o       = vout_q;
    assign data_serial_o = dout_q;

endmodule

// File: tb/tb_odd_even_sorter.sv
// Directed bench for odd_even_sorter: three instances (N=10 signed,
// N=4 unsigned, N=5 signed) checked against a queued reference.
module tb_odd_even_sorter;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] a_din, a_dout;
    logic        a_vin, a_desc, a_ready, a_vout, a_busy;
    logic [31:0] b_din, b_dout;
    logic        b_vin, b_desc, b_ready, b_vout, b_busy;
    logic [7:0]  c_din, c_dout;
    logic        c_vin, c_desc, c_ready, c_vout, c_busy;

    odd_even_sorter #(.DATA_W(32), .N(10), .SIGNED(1'b1)) u_a (
        .clk(clk), .rst(rst), .data_serial_i(a_din), .valid_i(a_vin),
        .desc_i(a_desc), .ready_o(a_ready), .data_serial_o(a_dout),
        .valid_o(a_vout), .busy_o(a_busy)
    );
    odd_even_sorter #(.DATA_W(32), .N(4), .SIGNED(1'b0)) u_b (
        .clk(clk), .rst(rst), .data_serial_i(b_din), .valid_i(b_vin),
        .desc_i(b_desc), .ready_o(b_ready), .data_serial_o(b_dout),
        .valid_o(b_vout), .busy_o(b_busy)
    );
    odd_even_sorter #(.DATA_W(8), .N(5), .SIGNED(1'b1)) u_c (
        .clk(clk), .rst(rst), .data_serial_i(c_din), .valid_i(c_vin),
        .desc_i(c_desc), .ready_o(c_ready), .data_serial_o(c_dout),
        .valid_o(c_vout), .busy_o(c_busy)
    );

    logic [31:0] qa [$];
    logic [31:0] qb [$];
    logic [7:0]  qc [$];
    logic [31:0] vec [10];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitors: every valid output pops one expected word
    always @(negedge clk) begin
        if (a_vout === 1'b1) begin
            logic [31:0] e;
            e = (qa.size() > 0) ? qa.pop_front() : 'x;
            chk("a_data", {32'd0, a_dout}, {32'd0, e});
        end
        if (b_vout === 1'b1) begin
            logic [31:0] e;
            e = (qb.size() > 0) ? qb.pop_front() : 'x;
            chk("b_data", {32'd0, b_dout}, {32'd0, e});
        end
        if (c_vout === 1'b1) begin
            logic [7:0] e;
            e = (qc.size() > 0) ? qc.pop_front() : 'x;
            chk("c_data", {56'd0, c_dout}, {56'd0, e});
        end
    end

    task automatic push_sorted(input bit desc);
        logic [31:0] t [10];
        logic [31:0] s;
        t = vec;
        for (int i = 1; i < 10; i++) begin
            for (int j = i; j > 0; j--) begin
                if (desc ? ($signed(t[j]) > $signed(t[j-1]))
                         : ($signed(t[j]) < $signed(t[j-1]))) begin
                    s = t[j]; t[j] = t[j-1]; t[j-1] = s;
                end
            end
        end
        for (int i = 0; i < 10; i++) qa.push_back(t[i]);
    endtask

    task automatic send_a(input bit desc, input bit toggle,
                          input int maxgap,
                          output int first_edge, output int last_edge);
        bit acc;
        int k;
        first_edge = 0;
        last_edge  = 0;
        for (int i = 0; i < 10; i++) begin
            if (maxgap > 0) begin
                repeat ($urandom_range(maxgap, 0)) begin
                    a_vin = 1'b0;
                    a_din = $urandom;
                    @(negedge clk);
                end
            end
            a_vin  = 1'b1;
            a_din  = vec[i];
            a_desc = (i == 0) ? desc : (toggle ? ~a_desc : desc);
            acc = 1'b0;
            k   = 0;
            while (!acc && k < 200) begin
                acc = a_ready;
                @(negedge clk);
                k++;
            end
            chk("a_accept", {63'd0, acc}, 64'd1);
            if (i == 0) first_edge = cyc;
            last_edge = cyc;
        end
        a_vin = 1'b0;
        push_sorted(desc);
    endtask

    task automatic wait_frame(input bit junk);
        int k  = 0;
        int nv = 0;
        while (a_vout !== 1'b1 && k < 200) begin
            if (junk && k < 5) begin
                a_vin = 1'b1;
                a_din = $urandom;
            end else begin
                a_vin = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        a_vin = 1'b0;
        chk("a_latency", 64'(k), 64'd11);
        while (a_ready !== 1'b1 && k < 200) begin
            if (a_vout === 1'b1) nv++;
            @(negedge clk);
            k++;
        end
        chk("a_nvalid", 64'(nv), 64'd10);
        chk("a_ready_back", 64'(k), 64'd21);
        chk("a_busy_idle", {63'd0, a_busy}, 64'd0);
    endtask

    int f1, e1, f2, e2, k, nv;
    logic [31:0] bv [4];
    logic [7:0]  cv [5];

    initial begin
        rst = 1'b1;
        a_vin = 0; a_din = 0; a_desc = 0;
        b_vin = 0; b_din = 0; b_desc = 0;
        c_vin = 0; c_din = 0; c_desc = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", {63'd0, a_ready}, 64'd1);
        chk("rst_valid", {63'd0, a_vout}, 64'd0);
        chk("rst_busy", {63'd0, a_busy}, 64'd0);
        chk("rst_dout", {32'd0, a_dout}, 64'd0);
        chk("rst_b_ready", {63'd0, b_ready}, 64'd1);

        // ascending signed
        vec = '{570, -347, 0, 383, -347, -881, 203, -281, 797, 345};
        send_a(1'b0, 1'b0, 0, f1, e1);
        chk("sort_busy", {63'd0, a_busy}, 64'd1);
        chk("sort_ready", {63'd0, a_ready}, 64'd0);
        wait_frame(1'b0);

        // descending, desc_i toggled on later words
        send_a(1'b1, 1'b1, 0, f1, e1);
        wait_frame(1'b0);

        // all equal with input gaps and valid_i during SORT
        vec = '{570, 570, 570, 570, 570, 570, 570, 570, 570, 570};
        send_a(1'b0, 1'b0, 3, f1, e1);
        wait_frame(1'b1);

        // reset pulsed during SORT phase 3
        vec = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
        send_a(1'b0, 1'b0, 0, f1, e1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        qa.delete();
        chk("abort_ready", {63'd0, a_ready}, 64'd1);
        chk("abort_valid", {63'd0, a_vout}, 64'd0);
        chk("abort_busy", {63'd0, a_busy}, 64'd0);
        nv = 0;
        repeat (25) begin
            @(negedge clk);
            if (a_vout === 1'b1) nv++;
        end
        chk("abort_nout", 64'(nv), 64'd0);

        // fresh frame after abort
        for (int i = 0; i < 10; i++) vec[i] = $urandom;
        send_a(1'b0, 1'b0, 0, f1, e1);
        wait_frame(1'b0);

        // back-to-back frames
        vec = '{-1, 2, -3, 4, -5, 6, -7, 8, -9, 10};
        send_a(1'b0, 1'b0, 0, f1, e1);
        vec = '{100, -100, 50, -50, 0, 7, 7, -7, 32767, -32768};
        send_a(1'b1, 1'b0, 0, f2, e2);
        chk("b2b_gap", 64'(f2 - e1), 64'd22);
        wait_frame(1'b0);

        // unsigned N=4
        bv = '{32'hFFFFFEA5, 32'h0000023A, 32'h0, 32'h80000000};
        qb.push_back(32'h0);
        qb.push_back(32'h0000023A);
        qb.push_back(32'h80000000);
        qb.push_back(32'hFFFFFEA5);
        for (int i = 0; i < 4; i++) begin
            b_vin = 1'b1; b_din = bv[i];
            @(negedge clk);
        end
        b_vin = 1'b0;
        k = 0;
        while (b_vout !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        chk("b_latency", 64'(k), 64'd5);
        repeat (6) @(negedge clk);
        chk("b_drained", 64'(qb.size()), 64'd0);

        // odd N=5, fully reversed input needs all 5 phases
        cv = '{8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        for (int i = 1; i <= 5; i++) qc.push_back(8'(i));
        for (int i = 0; i < 5; i++) begin
            c_vin = 1'b1; c_din = cv[i];
            @(negedge clk);
        end
        c_vin = 1'b0;
        k = 0;
        while (c_vout !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        chk("c_latency", 64'(k), 64'd6);
        while (c_ready !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        chk("c_ready_back", 64'(k), 64'd11);
        chk("c_drained", 64'(qc.size()), 64'd0);
        chk("a_drained", 64'(qa.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
